divider: RTL
============

# divider

Sequential signed divider: 32-bit two's-complement dividend by 16-bit two's-complement divisor, producing a 16-bit quotient and a 16-bit remainder. It is the inverse companion of the 16x16->32 Booth multiplier in the arithmetic unit. It takes a start pulse, runs one restoring-division bit per clock, and holds the result with a level done flag until the next request. It also flags divide-by-zero and quotient overflow so the ALU can raise exceptions.

## Interface
- DIVIDEND_W, 32, dividend width; quotient is computed internally at this width.
- DIVISOR_W, 16, divisor, quotient-out and remainder width.
- inp_clk  in  1  rising-edge clock.
- inp_rst_n  in  1  reset, asynchronous, active-low.
- inp_start  in  1  request; sampled every edge, accepted only in IDLE or DONE.
- inp_dividend  in  DIVIDEND_W  signed dividend; sampled on the accept edge only.
- inp_divisor  in  DIVISOR_W  signed divisor; sampled on the accept edge only.
- out_busy  out  1  high in RUN and FIX.
- out_done  out  1  level; high in DONE.
- out_quotient  out  DIVISOR_W  signed quotient, truncated toward zero.
- out_remainder  out  DIVISOR_W  signed remainder; sign follows the dividend.
- out_div_zero  out  1  last request had divisor 0.
- out_overflow  out  1  true quotient is outside [-32768, 32767].

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE/DONE to RUN on inp_start when divisor != 0.
  - IDLE/DONE to DONE on inp_start when divisor == 0.
  - RUN to FIX when counter reaches 0.
  - FIX to DONE.
- Accept edge actions:
  - Latch sign_q = dividend[31]^divisor[15] and sign_r = dividend[31].
  - Latch magnitude |dividend| (32-bit) and |divisor| (zero-extended 17-bit).
  - Clear the partial remainder and set counter = 32.
  - Clear out_done, out_div_zero and out_overflow.
- RUN, each edge:
  - trial = {partial_rem[15:0], dividend_msb} - divisor_mag.
  - If trial is non-negative: partial_rem = trial and shift 1 into the quotient.
  - Otherwise shift 0 into the quotient.
  - Decrement the counter.
- FIX edge:
  - Negate quotient_mag if sign_q; negate rem_mag if sign_r.
  - out_quotient = low 16 bits of the 32-bit signed quotient.
  - out_overflow = 1 if bits [31:15] of the signed quotient are not all equal.
  - out_remainder = signed remainder (always fits in 16 bits).
- Divide-by-zero: out_quotient = 16'hFFFF, out_remainder = inp_dividend[15:0], out_div_zero = 1, out_overflow = 0.
- Identity: dividend = quotient*divisor + remainder whenever out_overflow = 0.
- inp_start in RUN/FIX is ignored and the operand ports are don't-care.
- Results and flags hold in DONE until the next accept. Quotient and remainder stay stable until overwritten at the next completion.

## Timing
- Reset asserted: state = IDLE and every output = 0 immediately, including mid-operation. No partial result survives.
- Accept at edge E:
  - out_busy = 1 after E.
  - RUN steps occur at E+1..E+32.
  - FIX at E+33: out_done = 1 and results valid after E+33, out_busy = 0.
- Latency: 33 cycles normal, 1 cycle divide-by-zero (out_done after E+1, out_busy never set).
- Back-to-back: inp_start held high in DONE is accepted at the first DONE edge, so out_done drops after that edge. Throughput is one division per 34 cycles.
- out_done stays high until the next accept or reset; it is not a pulse.

## Structure
- Shared package (arith_pkg): DIVIDEND_W, DIVISOR_W, the FSM state enum, the divide-by-zero quotient constant 16'hFFFF, and a 32-cycle iteration-count constant.
- One sub-module, div_step: combinational restoring step. Inputs: partial remainder, incoming bit, divisor magnitude. Outputs: new remainder and quotient bit. It is unit-testable alone.
- Negate/abs helpers live as functions in arith_pkg.

## Test plan
- 100 / 7, start at E: out_done at E+33, q = 16'h000E, r = 16'h0002, both flags 0.
- -100 / 7: q = 16'hFFF2 (-14), r = 16'hFFFE (-2). Then 100 / -7: q = 16'hFFF2, r = 16'h0002.
- 1234 / 0: out_done after E+1, out_div_zero = 1, q = 16'hFFFF, r = 16'h04D2, out_busy never high.
- 32'h00010000 / 1: out_overflow = 1, q = 16'h0000. Then 32'h80000000 / -1: out_overflow = 1. Then -32768 / 1: overflow 0, q = 16'h8000.
- Start 100/7, pulse inp_start with 50/5 at E+5, then assert inp_rst_n = 0 at E+10:
  - The E+5 pulse is ignored.
  - On reset, all outputs are 0 with no clock edge.
  - After release, IDLE; a new start of 50/5 gives q = 10, r = 0 at its own E+33.
- Random signed operands (>=1000, divisor != 0): compare against the reference model. Check dividend == q*d + r and |r| < |d| when no overflow.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sequential signed divider:
// widths, FSM encoding, constants and two's-complement helpers.
package arith_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int CNT_W      = 6;

  // One restoring step per dividend bit.
  localparam logic [CNT_W-1:0] ITER_CNT = 6'd32;

  // Quotient reported for a zero divisor.
  localparam logic [DIVISOR_W-1:0] DIV_ZERO_Q = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  function automatic logic [DIVIDEND_W-1:0] neg32(input logic [DIVIDEND_W-1:0] v);
    return ~v + 32'd1;
  endfunction

  // |v| as an unsigned 32-bit value; the most negative dividend maps to 2^31.
  function automatic logic [DIVIDEND_W-1:0] abs32(input logic [DIVIDEND_W-1:0] v);
    return v[DIVIDEND_W-1] ? neg32(v) : v;
  endfunction

  function automatic logic [DIVISOR_W-1:0] neg16(input logic [DIVISOR_W-1:0] v);
    return ~v + 16'd1;
  endfunction

  // |v| zero-extended by one bit so that |-32768| = 32768 is representable.
  function automatic logic [DIVISOR_W:0] abs16_ext(input logic [DIVISOR_W-1:0] v);
    return {1'b0, (v[DIVISOR_W-1] ? neg16(v) : v)};
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module div_step
  import arith_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W:0]   dmag,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  // Two guard bits: one for the shifted-in bit, one for the borrow.
  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] trial;
  logic                 unused_trial_bit;

  assign shifted = {1'b0, rem_in, bit_in};
  assign trial   = shifted - {1'b0, dmag};

  // Borrow clear means the divisor fits; the result is then below dmag
  // (at most 32767), so the low 16 bits hold it exactly.
  assign q_bit            = ~trial[DIVISOR_W+1];
  assign rem_out          = q_bit ? trial[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
  assign unused_trial_bit = trial[DIVISOR_W];

endmodule

// File: rtl/divider.sv
// Sequential signed divider, 32-bit dividend by 16-bit divisor, one
// restoring step per clock on magnitudes with a final sign fix-up.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | after reset, waiting for inp_start
// ST_RUN  | 32 restoring steps on |dividend| / |divisor|
// ST_FIX  | apply signs, compute overflow, publish results
// ST_DONE | results held, out_done high, new request accepted
module divider
  import arith_pkg::*;
(
  input  logic                  inp_clk,
  input  logic                  inp_rst_n,
  input  logic                  inp_start,
  input  logic [DIVIDEND_W-1:0] inp_dividend,
  input  logic [DIVISOR_W-1:0]  inp_divisor,
  output logic                  out_busy,
  output logic                  out_done,
  output logic [DIVISOR_W-1:0]  out_quotient,
  output logic [DIVISOR_W-1:0]  out_remainder,
  output logic                  out_div_zero,
  output logic                  out_overflow
);

  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  // Holds |dividend| at accept; quotient bits shift in from the bottom
  // while dividend bits leave from the top.
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  prem;
  logic [DIVISOR_W:0]    dmag;
  logic                  sign_q;
  logic                  sign_r;

  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_qbit;
  logic [DIVIDEND_W-1:0] q_signed;
  logic [DIVISOR_W-1:0]  r_signed;

  div_step u_step (
    .rem_in  (prem),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .dmag    (dmag),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  // Signed results from the magnitudes, consumed in ST_FIX.
  always_comb begin
    q_signed = sign_q ? neg32(dvd_q) : dvd_q;
    r_signed = sign_r ? neg16(prem) : prem;
  end

  // Control FSM and datapath registers with registered outputs.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dvd_q         <= '0;
      prem          <= '0;
      dmag          <= '0;
      sign_q        <= 1'b0;
      sign_r        <= 1'b0;
      out_busy      <= 1'b0;
      out_done      <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div_zero  <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (inp_start) begin
            sign_q       <= inp_dividend[DIVIDEND_W-1] ^ inp_divisor[DIVISOR_W-1];
            sign_r       <= inp_dividend[DIVIDEND_W-1];
            dvd_q        <= abs32(inp_dividend);
            dmag         <= abs16_ext(inp_divisor);
            prem         <= '0;
            cnt          <= ITER_CNT;
            out_done     <= 1'b0;
            out_div_zero <= 1'b0;
            out_overflow <= 1'b0;
            if (inp_divisor == '0) begin
              // Zero divisor: results are fixed; out_done rises on the
              // following edge from ST_DONE.
              state         <= ST_DONE;
              out_quotient  <= DIV_ZERO_Q;
              out_remainder <= inp_dividend[DIVISOR_W-1:0];
              out_div_zero  <= 1'b1;
            end else begin
              state    <= ST_RUN;
              out_busy <= 1'b1;
            end
          end else if (state == ST_DONE) begin
            out_done <= 1'b1;
          end
        end
        ST_RUN: begin
          prem  <= step_rem;
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], step_qbit};
          cnt   <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          out_quotient  <= q_signed[DIVISOR_W-1:0];
          out_remainder <= r_signed;
          // Fits in 16 bits only if bits [31:15] are a pure sign extension.
          out_overflow  <= ~((&q_signed[DIVIDEND_W-1:DIVISOR_W-1]) |
                             ~(|q_signed[DIVIDEND_W-1:DIVISOR_W-1]));
          out_done      <= 1'b1;
          out_busy      <= 1'b0;
          state         <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
